// File: rtl/controlfsm.sv
// Multicycle control sequencer for the accumulator processor.
// Walks fetch, decode, execute and write-back states; reports halt, illegal and retired count.
module controlfsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic        zero,
    output logic [5:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instret
);

    // Encoding is fixed by the output decoder; gaps (26, 27, 33-63) are unused.
    typedef enum logic [5:0] {
        S_IDLE     = 6'd0,
        S_FETCH0   = 6'd1,
        S_FETCH1   = 6'd2,
        S_FETCH2   = 6'd3,
        S_FETCH3   = 6'd4,
        S_DECODE   = 6'd5,
        S_ST_ADDR  = 6'd6,
        S_LD_IMM   = 6'd7,
        S_ALU_IMM  = 6'd8,
        S_ALU_REG  = 6'd9,
        S_ALU_MD0  = 6'd10,
        S_ALU_MD1  = 6'd11,
        S_ALU_PC0  = 6'd12,
        S_ALU_PC1  = 6'd13,
        S_ALU_PC2  = 6'd14,
        S_ALU_PC3  = 6'd15,
        S_ALU_PC4  = 6'd16,
        S_ASR      = 6'd17,
        S_LSR      = 6'd18,
        S_ASL      = 6'd19,
        S_LSL      = 6'd20,
        S_JMP      = 6'd21,
        S_JZ       = 6'd22,
        S_JNZ      = 6'd23,
        S_POP      = 6'd24,
        S_PUSH     = 6'd25,
        S_ST_WR    = 6'd28,
        S_SHIFT_WB = 6'd29,
        S_ALU_WB   = 6'd30,
        S_HALT     = 6'd31,
        S_PCINC    = 6'd32
    } state_t;

    state_t      cur, nxt;
    logic        fetch_done;
    logic        ill_flag;
    logic [15:0] retired;
    logic        set_ill;
    logic        fd_set;
    logic        retire;

    logic [3:0] cls;
    logic [1:0] mode;
    logic [1:0] len;
    assign cls  = op[7:4];
    assign mode = op[3:2];
    assign len  = op[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_IDLE;
            fetch_done <= 1'b0;
            ill_flag   <= 1'b0;
            retired    <= 16'd0;
        end else begin
            cur <= nxt;
            if (nxt == S_FETCH0)
                fetch_done <= 1'b0;
            else if (fd_set)
                fetch_done <= 1'b1;
            if (set_ill)
                ill_flag <= 1'b1;
            if (retire)
                retired <= retired + 16'd1;
        end
    end

    always_comb begin
        nxt     = cur;
        set_ill = 1'b0;
        case (cur)
            S_IDLE:     if (start) nxt = S_FETCH0;
            S_FETCH0:   nxt = S_DECODE;
            S_FETCH1:   nxt = (len >= 2'd2) ? S_FETCH2 : S_DECODE;
            S_FETCH2:   nxt = (len == 2'd3) ? S_FETCH3 : S_DECODE;
            S_FETCH3:   nxt = S_DECODE;
            S_DECODE: begin
                if (len != 2'd0 && !fetch_done) begin
                    nxt = S_FETCH1;
                end else begin
                    case (cls)
                        4'h0: nxt = S_PCINC;
                        4'h1: begin
                            if (mode == 2'b00) begin
                                nxt = S_LD_IMM;
                            end else begin
                                nxt     = S_HALT;
                                set_ill = 1'b1;
                            end
                        end
                        4'h2: begin
                            case (mode)
                                2'b00:   nxt = S_ALU_IMM;
                                2'b01:   nxt = S_ALU_REG;
                                2'b10:   nxt = S_ALU_MD0;
                                default: nxt = S_ALU_PC0;
                            endcase
                        end
                        4'h3: nxt = S_ST_ADDR;
                        4'h4: nxt = S_ASR;
                        4'h5: nxt = S_LSR;
                        4'h6: nxt = S_ASL;
                        4'h7: nxt = S_LSL;
                        4'h8: nxt = S_JMP;
                        4'h9: nxt = S_JZ;
                        4'hA: nxt = S_JNZ;
                        4'hB: nxt = S_POP;
                        4'hC: nxt = S_PUSH;
                        4'hF: nxt = S_HALT;
                        default: begin
                            nxt     = S_HALT;
                            set_ill = 1'b1;
                        end
                    endcase
                end
            end
            S_LD_IMM, S_ST_WR, S_SHIFT_WB, S_ALU_WB, S_POP, S_PUSH:
                nxt = S_PCINC;
            S_ALU_IMM, S_ALU_REG, S_ALU_MD1, S_ALU_PC4:
                nxt = S_ALU_WB;
            S_ALU_MD0:  nxt = S_ALU_MD1;
            S_ALU_PC0:  nxt = S_ALU_PC1;
            S_ALU_PC1:  nxt = S_ALU_PC2;
            S_ALU_PC2:  nxt = S_ALU_PC3;
            S_ALU_PC3:  nxt = S_ALU_PC4;
            S_ST_ADDR:  nxt = S_ST_WR;
            S_ASR, S_LSR, S_ASL, S_LSL:
                nxt = S_SHIFT_WB;
            // Branch states write the PC themselves, so a taken branch skips PCINC.
            S_JMP:      nxt = S_FETCH0;
            S_JZ:       nxt = zero ? S_FETCH0 : S_PCINC;
            S_JNZ:      nxt = zero ? S_PCINC : S_FETCH0;
            S_PCINC:    nxt = S_FETCH0;
            S_HALT:     nxt = S_HALT;
            default: begin
                nxt     = S_HALT;
                set_ill = 1'b1;
            end
        endcase
    end

    assign fd_set = (cur == S_FETCH1 || cur == S_FETCH2 || cur == S_FETCH3) && (nxt == S_DECODE);
    assign retire = (nxt == S_FETCH0) && (cur != S_IDLE);

    assign state   = cur;
    assign halted  = (cur == S_HALT);
    assign illegal = ill_flag;
    assign instret = retired;

endmodule

// File: tb/tb_controlfsm.sv
// Self-checking bench for controlfsm: table of instructions with expected state walks,
// scoreboard queue of expected states, plus hand-written halt/illegal/reset/wrap cases.
module tb_controlfsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op;
    logic        zero;
    logic [5:0]  state;
    logic        halted;
    logic        illegal;
    logic [15:0] instret;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model_instret;
    int exp_q[$];

    typedef struct {
        logic [7:0] op;
        logic       z;
        int         seq[16];
    } vec_t;

    vec_t vecs[19];

    controlfsm dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .zero    (zero),
        .state   (state),
        .halted  (halted),
        .illegal (illegal),
        .instret (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected walk up to and including the return to state 1, then drains it.
    task automatic run_vec(input vec_t v);
        int e;
        op   = v.op;
        zero = v.z;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(v.seq[k]);
            if (v.seq[k] == 1) break;
        end
        model_instret = model_instret + 16'd1;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check("state", int'(state), e);
        end
        check("instret", int'(instret), int'(model_instret));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_instret = 16'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_to_fetch", int'(state), 1);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 1'b0, '{5,32,1,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[1]  = '{8'h00, 1'b0, '{5,32,1,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[2]  = '{8'h2F, 1'b0, '{5,2,3,4,5,12,13,14,15,16,30,32,1,0,0,0}};
        vecs[3]  = '{8'h91, 1'b1, '{5,2,5,22,1,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[4]  = '{8'h91, 1'b0, '{5,2,5,22,32,1,0,0,0,0,0,0,0,0,0,0}};
        vecs[5]  = '{8'h21, 1'b0, '{5,2,5,8,30,32,1,0,0,0,0,0,0,0,0,0}};
        vecs[6]  = '{8'h81, 1'b0, '{5,2,5,21,1,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[7]  = '{8'h10, 1'b0, '{5,7,32,1,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[8]  = '{8'h33, 1'b0, '{5,2,3,4,5,6,28,32,1,0,0,0,0,0,0,0}};
        vecs[9]  = '{8'h62, 1'b0, '{5,2,3,5,19,29,32,1,0,0,0,0,0,0,0,0}};
        vecs[10] = '{8'hA0, 1'b0, '{5,23,1,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[11] = '{8'hA0, 1'b1, '{5,23,32,1,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[12] = '{8'hB0, 1'b0, '{5,24,32,1,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[13] = '{8'hC0, 1'b0, '{5,25,32,1,0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[14] = '{8'h24, 1'b0, '{5,9,30,32,1,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[15] = '{8'h28, 1'b0, '{5,10,11,30,32,1,0,0,0,0,0,0,0,0,0,0}};
        vecs[16] = '{8'h40, 1'b0, '{5,17,29,32,1,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[17] = '{8'h50, 1'b0, '{5,18,29,32,1,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[18] = '{8'h70, 1'b0, '{5,20,29,32,1,0,0,0,0,0,0,0,0,0,0,0}};

        start = 1'b0;
        op    = 8'h00;
        zero  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_instret = 16'd0;
        check("rst_state",   int'(state),   0);
        check("rst_halted",  int'(halted),  0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_instret", int'(instret), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", int'(state), 0);
        end
        do_start();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal class D: decode then halt with both flags in the same cycle.
        op = 8'hD0;
        tick();
        check("ill_decode", int'(state), 5);
        check("ill_not_yet", int'(illegal), 0);
        tick();
        check("ill_state", int'(state), 31);
        check("ill_flag", int'(illegal), 1);
        check("ill_halted", int'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick();
            check("halt_hold", int'(state), 31);
        end
        start = 1'b0;
        do_reset();
        check("post_halt_state",   int'(state),   0);
        check("post_halt_illegal", int'(illegal), 0);
        check("post_halt_halted",  int'(halted),  0);
        check("post_halt_instret", int'(instret), 0);

        // LD with a non-immediate mode is illegal.
        do_start();
        op = 8'h14;
        tick();
        check("ldreg_decode", int'(state), 5);
        tick();
        check("ldreg_state", int'(state), 31);
        check("ldreg_illegal", int'(illegal), 1);
        do_reset();

        // Reset dominates an in-flight pcrel ALU instruction in state 14.
        do_start();
        op = 8'h2F;
        exp_q = '{5,2,3,4,5,12,13,14};
        while (exp_q.size() > 0) begin
            int e;
            tick();
            e = exp_q.pop_front();
            check("pre_rst_walk", int'(state), e);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_state", int'(state), 0);
        check("midrst_instret", int'(instret), 0);
        model_instret = 16'd0;

        // Retired counter wraps from 0xFFFF to 0.
        do_start();
        force dut.retired = 16'hFFFF;
        #1;
        release dut.retired;
        model_instret = 16'hFFFF;
        run_vec(vecs[0]);
        check("wrap_zero", int'(instret), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
